store_buffer_ctrl: RTL and testbench

- Posted-write store buffer between the MEM-stage byte-enable/data alignment logic and the data-memory write port.
- Accepts aligned stores (word address, 4-bit byte enable, lane-aligned write data) and queues them in a FIFO.
- Drains the queue to memory under a req/gnt handshake.
- Flags loads that hit a pending store word, so the hazard unit can stall them.

---
 rtl/store_buffer_ctrl_if.sv | 31 +++
 rtl/store_buffer_ctrl.sv | 116 +++++++++++
 tb/tb_store_buffer_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_ctrl_if.sv
// Store-buffer bus bundle: store intake, memory write port, load hazard check, and occupancy status.
// The slave modport is the buffer side; the master modport is the producer/memory/hazard side.
interface store_buffer_ctrl_if #(
    parameter int PTR_W = 2
);
    logic             st_valid;
    logic             st_ready;
    logic [31:0]      st_addr;
    logic [3:0]       st_byteen;
    logic [31:0]      st_wdata;
    logic             mem_req;
    logic             mem_gnt;
    logic [31:0]      mem_addr;
    logic [3:0]       mem_byteen;
    logic [31:0]      mem_wdata;
    logic             ld_check;
    logic [31:0]      ld_addr;
    logic             ld_hazard;
    logic [PTR_W:0]   count;
    logic             empty;

    modport slave (
        input  st_valid, st_addr, st_byteen, st_wdata, mem_gnt, ld_check, ld_addr,
        output st_ready, mem_req, mem_addr, mem_byteen, mem_wdata, ld_hazard, count, empty
    );

    modport master (
        output st_valid, st_addr, st_byteen, st_wdata, mem_gnt, ld_check, ld_addr,
        input  st_ready, mem_req, mem_addr, mem_byteen, mem_wdata, ld_hazard, count, empty
    );
endinterface

// File: rtl/store_buffer_ctrl.sv
// Posted-write store buffer: queues aligned stores in order and drains them to the data-memory
// write port under req/gnt, flagging loads that hit a pending or incoming store word.
module store_buffer_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    store_buffer_ctrl_if.slave   sb
);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   ZERO_CNT = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [29:0]      word_q [DEPTH];
    logic [29:0]      word_d [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [3:0]       be_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];

    logic             accept_s;
    logic             enq_s;
    logic             deq_s;
    logic             hit_s;
    logic [PTR_W-1:0] off_s;
    logic             addr_lsb_unused_s;

    // Handshake, pointer/count next-state and entry write.
    always_comb begin
        accept_s = sb.st_valid && (count_q != FULL_CNT);
        // A zero byte-enable store completes its handshake but occupies no entry.
        enq_s    = accept_s && (sb.st_byteen != 4'b0000);
        deq_s    = (count_q != ZERO_CNT) && sb.mem_gnt;
        wr_ptr_d = enq_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = deq_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
        word_d = word_q;
        be_d   = be_q;
        data_d = data_q;
        if (enq_s) begin
            word_d[wr_ptr_q] = sb.st_addr[31:2];
            be_d[wr_ptr_q]   = sb.st_byteen;
            data_d[wr_ptr_q] = sb.st_wdata;
        end else begin
            word_d[wr_ptr_q] = word_q[wr_ptr_q];
        end
    end

    // Load hazard: word match against occupied entries (head included) or the store being enqueued.
    always_comb begin
        hit_s = 1'b0;
        off_s = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off_s = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, off_s} < count_q) && (word_q[i] == sb.ld_addr[31:2])) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
        if (enq_s && (sb.st_addr[31:2] == sb.ld_addr[31:2])) begin
            hit_s = 1'b1;
        end else begin
            hit_s = hit_s;
        end
        addr_lsb_unused_s = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};
    end

    // Port outputs; head fields are forced to zero while the queue is empty.
    always_comb begin
        sb.st_ready  = (count_q != FULL_CNT);
        sb.mem_req   = (count_q != ZERO_CNT);
        sb.count     = count_q;
        sb.empty     = (count_q == ZERO_CNT);
        sb.ld_hazard = sb.ld_check && hit_s;
        if (count_q != ZERO_CNT) begin
            sb.mem_addr   = {word_q[rd_ptr_q], 2'b00};
            sb.mem_byteen = be_q[rd_ptr_q];
            sb.mem_wdata  = data_q[rd_ptr_q];
        end else begin
            sb.mem_addr   = 32'h0000_0000;
            sb.mem_byteen = 4'b0000;
            sb.mem_wdata  = 32'h0000_0000;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= ZERO_CNT;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= 30'h0000_0000;
                be_q[i]   <= 4'b0000;
                data_q[i] <= 32'h0000_0000;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            word_q   <= word_d;
            be_q     <= be_d;
            data_q   <= data_d;
        end
    end
endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Directed bench for store_buffer_ctrl: a queue of expected memory writes is filled as stores are
// accepted and checked against the memory port every cycle, plus targeted literal checks.
module tb_store_buffer_ctrl;
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    txn_t exp_q[$];

    store_buffer_ctrl_if #(.PTR_W(2)) sb_if ();

    store_buffer_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic gnt);
        sb_if.st_valid  = v;
        sb_if.st_addr   = a;
        sb_if.st_byteen = be;
        sb_if.st_wdata  = d;
        sb_if.mem_gnt   = gnt;
    endtask

    // One cycle: compare outputs with the scoreboard, then apply grant/accept to the model.
    task automatic tick();
        logic full;
        logic acc;
        logic hz;
        int   n;
        #3;
        n    = exp_q.size();
        full = (n == 4);
        acc  = sb_if.st_valid && !full && (sb_if.st_byteen != 4'b0000);
        hz   = 1'b0;
        for (int i = 0; i < n; i++)
            if (exp_q[i].addr[31:2] == sb_if.ld_addr[31:2]) hz = 1'b1;
        if (acc && (sb_if.st_addr[31:2] == sb_if.ld_addr[31:2])) hz = 1'b1;
        hz = hz && sb_if.ld_check;
        chk("count", 32'(sb_if.count), 32'(n));
        chk("empty", 32'(sb_if.empty), 32'(n == 0));
        chk("mem_req", 32'(sb_if.mem_req), 32'(n != 0));
        chk("st_ready", 32'(sb_if.st_ready), 32'(!full));
        chk("ld_hazard", 32'(sb_if.ld_hazard), 32'(hz));
        if (n > 0) begin
            chk("head_addr", sb_if.mem_addr, exp_q[0].addr);
            chk("head_be", 32'(sb_if.mem_byteen), 32'(exp_q[0].be));
            chk("head_data", sb_if.mem_wdata, exp_q[0].data);
        end else begin
            chk("idle_addr", sb_if.mem_addr, 32'h0000_0000);
            chk("idle_data", sb_if.mem_wdata, 32'h0000_0000);
        end
        if (sb_if.mem_gnt && (n > 0)) void'(exp_q.pop_front());
        if (acc) exp_q.push_back('{addr: {sb_if.st_addr[31:2], 2'b00},
                                   be: sb_if.st_byteen, data: sb_if.st_wdata});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        sb_if.ld_check = 1'b0;
        sb_if.ld_addr  = 32'h0000_0000;
        drive(1'b0, 32'h0, 4'b0000, 32'h0, 1'b0);
        #2;
        chk("rst_mem_req", 32'(sb_if.mem_req), 32'h0);
        chk("rst_empty", 32'(sb_if.empty), 32'h1);
        chk("rst_st_ready", 32'(sb_if.st_ready), 32'h1);
        #10 reset = 1'b0;
        @(posedge clk);
        #1;

        // Idle queue, load check finds nothing.
        sb_if.ld_check = 1'b1;
        sb_if.ld_addr  = 32'h0000_0100;
        tick();

        // Single store held without grant, then granted.
        drive(1'b1, 32'h0000_1006, 4'b1100, 32'hBEEF_0000, 1'b0);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 32'h0, 1'b0);
        #1;
        chk("single_addr", sb_if.mem_addr, 32'h0000_1004);
        chk("single_be", 32'(sb_if.mem_byteen), 32'hC);
        chk("single_count", 32'(sb_if.count), 32'h1);
        repeat (5) tick();
        sb_if.mem_gnt = 1'b1;
        tick();
        sb_if.mem_gnt = 1'b0;
        chk("single_done_req", 32'(sb_if.mem_req), 32'h0);
        chk("single_done_empty", 32'(sb_if.empty), 32'h1);

        // Fill to full, refuse a fifth store, drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(4 * i), 4'b1111, 32'hC0 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b1, 32'h0000_0020, 4'b1111, 32'hDEAD_DEAD, 1'b0);
        chk("full_count", 32'(sb_if.count), 32'h4);
        chk("full_ready", 32'(sb_if.st_ready), 32'h0);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 32'h0, 1'b1);
        #1;
        chk("full_head", sb_if.mem_addr, 32'h0000_0010);
        tick();
        chk("ready_after_gnt", 32'(sb_if.st_ready), 32'h1);
        repeat (3) tick();
        sb_if.mem_gnt = 1'b0;
        tick();

        // Concurrent enqueue/dequeue at count 2 with pointer wrap.
        drive(1'b1, 32'h0000_0040, 4'b1111, 32'h90, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0044, 4'b1111, 32'h91, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h48 + 32'(4 * i), 4'b1111, 32'hA1 + 32'(i), 1'b1);
            tick();
            chk("steady_count", 32'(sb_if.count), 32'h2);
        end
        drive(1'b0, 32'h0, 4'b0000, 32'h0, 1'b1);
        repeat (2) tick();
        sb_if.mem_gnt = 1'b0;
        tick();

        // Load hazard against a pending store, then against an incoming one.
        sb_if.ld_check = 1'b0;
        drive(1'b1, 32'h0000_0200, 4'b0011, 32'h55, 1'b0);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 32'h0, 1'b0);
        sb_if.ld_check = 1'b1;
        sb_if.ld_addr  = 32'h0000_0203;
        #1;
        chk("hz_same_word", 32'(sb_if.ld_hazard), 32'h1);
        tick();
        sb_if.ld_addr = 32'h0000_0204;
        #1;
        chk("hz_next_word", 32'(sb_if.ld_hazard), 32'h0);
        tick();
        sb_if.ld_addr = 32'h0000_0200;
        sb_if.mem_gnt = 1'b1;
        #1;
        chk("hz_granted_head", 32'(sb_if.ld_hazard), 32'h1);
        tick();
        drive(1'b1, 32'h0000_0300, 4'b1111, 32'h77, 1'b0);
        sb_if.ld_addr = 32'h0000_0300;
        #1;
        chk("hz_incoming", 32'(sb_if.ld_hazard), 32'h1);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 32'h0, 1'b0);
        sb_if.ld_check = 1'b0;
        #1;
        chk("hz_no_check", 32'(sb_if.ld_hazard), 32'h0);
        sb_if.mem_gnt = 1'b1;
        tick();
        sb_if.mem_gnt = 1'b0;
        sb_if.ld_check = 1'b1;

        // Null store: accepted but never written.
        drive(1'b1, 32'h0000_0400, 4'b0000, 32'h99, 1'b0);
        chk("null_ready", 32'(sb_if.st_ready), 32'h1);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 32'h0, 1'b0);
        chk("null_count", 32'(sb_if.count), 32'h0);
        chk("null_req", 32'(sb_if.mem_req), 32'h0);
        tick();

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 4'b1111, 32'hE0 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 4'b0000, 32'h0, 1'b1);
        chk("pre_rst_count", 32'(sb_if.count), 32'h3);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", 32'(sb_if.mem_req), 32'h0);
        chk("mid_rst_count", 32'(sb_if.count), 32'h0);
        chk("mid_rst_empty", 32'(sb_if.empty), 32'h1);
        exp_q.delete();
        sb_if.mem_gnt = 1'b0;
        #1 reset = 1'b0;
        drive(1'b1, 32'h0000_0600, 4'b0101, 32'h1234_5678, 1'b0);
        tick();
        drive(1'b0, 32'h0, 4'b0000, 32'h0, 1'b0);
        chk("post_rst_addr", sb_if.mem_addr, 32'h0000_0600);
        chk("post_rst_be", 32'(sb_if.mem_byteen), 32'h5);
        chk("post_rst_data", sb_if.mem_wdata, 32'h1234_5678);
        tick();
        sb_if.mem_gnt = 1'b1;
        tick();
        sb_if.mem_gnt = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
